// File: rtl/sni_multi_pattern_match_if.sv
// rtl/sni_multi_pattern_match_if.sv - beat input and result output bundle for the SNI matcher
interface sni_multi_pattern_match_if #(
  parameter int IN_BYTES = 8,
  parameter int NUM_PAT  = 8,
  parameter int ID_W     = 8,
  parameter int TYPE_W   = 3
);
  logic [8*IN_BYTES-1:0]    i_data;
  logic [IN_BYTES-1:0]      i_keep;
  logic                     i_last;
  logic [ID_W-1:0]          i_flow_id;
  logic [TYPE_W-1:0]        i_flow_type;
  logic                     i_valid;
  logic                     o_ready;
  logic [ID_W+TYPE_W+4:0]   o_flow_id_type;
  logic [NUM_PAT-1:0]       o_hit_mask;
  logic                     o_res_valid;
  logic                     i_res_ready;

  modport slave (
    input  i_data, i_keep, i_last, i_flow_id, i_flow_type, i_valid, i_res_ready,
    output o_ready, o_flow_id_type, o_hit_mask, o_res_valid
  );

  modport master (
    output i_data, i_keep, i_last, i_flow_id, i_flow_type, i_valid, i_res_ready,
    input  o_ready, o_flow_id_type, o_hit_mask, o_res_valid
  );
endinterface

// File: rtl/sni_multi_pattern_match.sv
// rtl/sni_multi_pattern_match.sv - programmable multi-pattern SNI matcher with beat FIFO
module sni_multi_pattern_match #(
  parameter int IN_BYTES   = 8,
  parameter int NUM_PAT    = 8,
  parameter int PAT_LEN    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ID_W       = 8,
  parameter int TYPE_W     = 3,
  localparam int PAT_W     = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
  localparam int IDX_W     = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_we,
  input  logic [PAT_W-1:0]  i_cfg_pat,
  input  logic [IDX_W-1:0]  i_cfg_byte_idx,
  input  logic              i_cfg_is_len,
  input  logic [7:0]        i_cfg_data,
  output logic              o_cfg_err,
  output logic              o_busy,
  sni_multi_pattern_match_if.slave bus
);

  localparam int NB_W  = $clog2(IN_BYTES + 1);
  localparam int BI_W  = $clog2(IN_BYTES);
  localparam int LEN_W = $clog2(PAT_LEN + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [IN_BYTES-1:0][7:0] data;
    logic [IN_BYTES-1:0]      keep;
    logic                     last;
    logic [ID_W-1:0]          id;
    logic [TYPE_W-1:0]        typ;
  } beat_t;

  // Element 0 is the most recently shifted byte.
  typedef logic [PAT_LEN-1:0][7:0] win_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_REPORT} state_t;

  // Pattern table
  win_t             pat_q [NUM_PAT];
  win_t             pat_d [NUM_PAT];
  logic [LEN_W-1:0] len_q [NUM_PAT];
  logic [LEN_W-1:0] len_d [NUM_PAT];
  logic             cfg_err_q, cfg_err_d;

  // Beat FIFO
  beat_t            mem_q [FIFO_DEPTH];
  beat_t            mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push, pop;
  beat_t            in_beat, head;
  logic [NB_W-1:0]  head_nb;

  // Scanner
  state_t             state_q, state_d;
  beat_t              beat_q, beat_d;
  logic [NB_W-1:0]    nb_q, nb_d;
  logic [NB_W-1:0]    pos_q, pos_d;
  win_t               win_q, win_d;
  logic [LEN_W-1:0]   bcnt_q, bcnt_d;
  logic [NUM_PAT-1:0] mask_q, mask_d;
  logic               res_valid_q, res_valid_d;
  logic [ID_W+TYPE_W+4:0] fit_q, fit_d;
  logic [NUM_PAT-1:0] hit_q, hit_d;

  logic [7:0]         b0, b1;
  win_t               w1, w2;
  logic [LEN_W-1:0]   c1, c2;
  logic [NUM_PAT-1:0] h1, h2, scan_mask;
  logic               two, fin;

  function automatic win_t shift_in(input win_t w, input logic [7:0] b);
    win_t r;
    r[0] = b;
    for (int k = 1; k < PAT_LEN; k++) r[IDX_W'(k)] = w[IDX_W'(k - 1)];
    return r;
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] c);
    return (c == LEN_W'(PAT_LEN)) ? c : c + LEN_W'(1);
  endfunction

  // A slot hits when its last L window bytes match and at least L message bytes were seen.
  function automatic logic [NUM_PAT-1:0] hits_of(input win_t w, input logic [LEN_W-1:0] c);
    logic [NUM_PAT-1:0] h;
    logic               ok;
    int                 l;
    h = '0;
    for (int p = 0; p < NUM_PAT; p++) begin
      l  = int'(len_q[PAT_W'(p)]);
      ok = (l != 0) && (c >= len_q[PAT_W'(p)]);
      for (int k = 0; k < PAT_LEN; k++) begin
        if (k < l && w[IDX_W'(k)] != pat_q[PAT_W'(p)][IDX_W'(l - 1 - k)]) ok = 1'b0;
      end
      h[PAT_W'(p)] = ok;
    end
    return h;
  endfunction

  function automatic logic [4:0] code_of(input logic [NUM_PAT-1:0] m);
    logic [4:0] c;
    c = '0;
    for (int p = NUM_PAT - 1; p >= 0; p--) begin
      if (m[PAT_W'(p)]) c = 5'(p + 1);
    end
    return c;
  endfunction

  function automatic logic [NB_W-1:0] nbytes_of(input beat_t b);
    int n;
    n = 0;
    for (int i = 0; i < IN_BYTES; i++) begin
      if (b.keep[BI_W'(i)]) n++;
    end
    return b.last ? NB_W'(n) : NB_W'(IN_BYTES);
  endfunction

  assign in_beat = {bus.i_data, bus.i_keep, bus.i_last, bus.i_flow_id, bus.i_flow_type};
  assign head    = mem_q[rp_q];
  assign head_nb = nbytes_of(head);
  assign push    = bus.i_valid & bus.o_ready;

  assign bus.o_ready        = (cnt_q != (AW + 1)'(FIFO_DEPTH));
  assign bus.o_res_valid    = res_valid_q;
  assign bus.o_flow_id_type = fit_q;
  assign bus.o_hit_mask     = hit_q;
  assign o_cfg_err          = cfg_err_q;
  assign o_busy             = (cnt_q != '0) || (state_q != S_IDLE);

  // Config writes land only while idle; anything else is reported and dropped.
  always_comb begin
    pat_d     = pat_q;
    len_d     = len_q;
    cfg_err_d = 1'b0;
    if (i_cfg_we) begin
      if (o_busy) begin
        cfg_err_d = 1'b1;
      end else if (i_cfg_is_len) begin
        len_d[i_cfg_pat] = (int'(i_cfg_data) > PAT_LEN) ? LEN_W'(PAT_LEN) : LEN_W'(i_cfg_data);
      end else begin
        pat_d[i_cfg_pat][i_cfg_byte_idx] = i_cfg_data;
      end
    end
  end

  // Pattern table and error pulse registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pat_q     <= '{default: '0};
      len_q     <= '{default: '0};
      cfg_err_q <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      len_q     <= len_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // FIFO storage write and pointer/occupancy update
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = in_beat;
    wp_d  = wp_q + AW'(push);
    rp_d  = rp_q + AW'(pop);
    cnt_d = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
  end

  // FIFO payload storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Scanner FSM: next state, byte-pair matching and result capture
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    nb_d        = nb_q;
    pos_d       = pos_q;
    win_d       = win_q;
    bcnt_d      = bcnt_q;
    mask_d      = mask_q;
    res_valid_d = res_valid_q;
    fit_d       = fit_q;
    hit_d       = hit_q;
    pop         = 1'b0;

    b0        = beat_q.data[BI_W'(IN_BYTES - 1 - int'(pos_q))];
    b1        = beat_q.data[BI_W'(IN_BYTES - 2 - int'(pos_q))];
    w1        = shift_in(win_q, b0);
    c1        = sat_inc(bcnt_q);
    h1        = hits_of(w1, c1);
    w2        = shift_in(w1, b1);
    c2        = sat_inc(c1);
    h2        = hits_of(w2, c2);
    two       = (int'(pos_q) + 1) < int'(nb_q);
    fin       = (int'(pos_q) + 2) >= int'(nb_q);
    scan_mask = mask_q | h1 | (two ? h2 : '0);

    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          state_d = S_LOAD;
          win_d   = '0;
          bcnt_d  = '0;
          mask_d  = '0;
        end
      end
      S_LOAD: begin
        if (cnt_q != '0) begin
          pop    = 1'b1;
          beat_d = head;
          nb_d   = head_nb;
          pos_d  = '0;
          if (head.last && head_nb == '0) begin
            state_d     = S_REPORT;
            res_valid_d = 1'b1;
            hit_d       = mask_q;
            fit_d       = {head.id, head.typ, code_of(mask_q)};
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        win_d  = two ? w2 : w1;
        bcnt_d = two ? c2 : c1;
        mask_d = scan_mask;
        pos_d  = pos_q + NB_W'(2);
        if (fin) begin
          if (beat_q.last) begin
            state_d     = S_REPORT;
            res_valid_d = 1'b1;
            hit_d       = scan_mask;
            fit_d       = {beat_q.id, beat_q.typ, code_of(scan_mask)};
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_REPORT: begin
        if (bus.i_res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scanner and result registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      nb_q        <= '0;
      pos_q       <= '0;
      win_q       <= '0;
      bcnt_q      <= '0;
      mask_q      <= '0;
      res_valid_q <= 1'b0;
      fit_q       <= '0;
      hit_q       <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      nb_q        <= nb_d;
      pos_q       <= pos_d;
      win_q       <= win_d;
      bcnt_q      <= bcnt_d;
      mask_q      <= mask_d;
      res_valid_q <= res_valid_d;
      fit_q       <= fit_d;
      hit_q       <= hit_d;
    end
  end

endmodule

// File: tb/tb_sni_multi_pattern_match.sv
// tb/tb_sni_multi_pattern_match.sv - scoreboard bench for the SNI multi-pattern matcher
module tb_sni_multi_pattern_match;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [2:0] cfg_pat;
  logic [2:0] cfg_idx;
  logic       cfg_is_len;
  logic [7:0] cfg_data;
  logic       cfg_err;
  logic       busy;

  sni_multi_pattern_match_if #(.IN_BYTES(8), .NUM_PAT(8), .ID_W(8), .TYPE_W(3)) bus ();

  sni_multi_pattern_match #(
    .IN_BYTES(8), .NUM_PAT(8), .PAT_LEN(8), .FIFO_DEPTH(16), .ID_W(8), .TYPE_W(3)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_cfg_we       (cfg_we),
    .i_cfg_pat      (cfg_pat),
    .i_cfg_byte_idx (cfg_idx),
    .i_cfg_is_len   (cfg_is_len),
    .i_cfg_data     (cfg_data),
    .o_cfg_err      (cfg_err),
    .o_busy         (busy),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] fit;
    logic [7:0]  mask;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] str8(input string s);
    logic [63:0] r;
    logic [7:0]  c;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      c = (i < s.len()) ? s[i] : 8'h2e;
      r = {r[55:0], c};
    end
    return r;
  endfunction

  task automatic expect_res(input logic [7:0] id, input logic [2:0] typ, input logic [4:0] code,
                            input logic [7:0] mask);
    exp_q.push_back({id, typ, code, mask});
  endtask

  task automatic cfg_write(input int p, input int idx, input logic is_len, input logic [7:0] d);
    cfg_pat    = 3'(p);
    cfg_idx    = 3'(idx);
    cfg_is_len = is_len;
    cfg_data   = d;
    cfg_we     = 1'b1;
    @(negedge clk);
    cfg_we     = 1'b0;
  endtask

  task automatic program_pat(input int slot, input string s, input logic [7:0] len);
    for (int i = 0; i < s.len(); i++) cfg_write(slot, i, 1'b0, s[i]);
    cfg_write(slot, 0, 1'b1, len);
  endtask

  task automatic send_beat(input string s, input logic [7:0] keep, input logic last,
                           input logic [7:0] id, input logic [2:0] typ);
    int n;
    bus.i_data      = str8(s);
    bus.i_keep      = keep;
    bus.i_last      = last;
    bus.i_flow_id   = id;
    bus.i_flow_type = typ;
    bus.i_valid     = 1'b1;
    n = 0;
    while (!bus.o_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=ready_low required=ready_high");
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < 2000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Monitor: every accepted result is compared against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.o_res_valid && bus.i_res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=0x%0h required=none", bus.o_flow_id_type);
        end else begin
          e = exp_q.pop_front();
          check("result_flow_id_type", 32'(bus.o_flow_id_type), 32'(e.fit));
          check("result_hit_mask", 32'(bus.o_hit_mask), 32'(e.mask));
        end
      end
    end
  end

  initial begin
    logic [15:0] held_fit;
    logic [7:0]  held_mask;
    logic        stable;
    logic        early;
    int          n;

    rst_n           = 1'b0;
    cfg_we          = 1'b0;
    cfg_pat         = '0;
    cfg_idx         = '0;
    cfg_is_len      = 1'b0;
    cfg_data        = '0;
    bus.i_data      = '0;
    bus.i_keep      = '0;
    bus.i_last      = 1'b0;
    bus.i_flow_id   = '0;
    bus.i_flow_type = '0;
    bus.i_valid     = 1'b0;
    bus.i_res_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset_ready", 32'(bus.o_ready), 32'd1);
    check("reset_res_valid", 32'(bus.o_res_valid), 32'd0);
    check("reset_flow_id_type", 32'(bus.o_flow_id_type), 32'd0);
    check("reset_hit_mask", 32'(bus.o_hit_mask), 32'd0);
    check("reset_cfg_err", 32'(cfg_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Single beat, latency and packed output.
    program_pat(1, "imap", 8'd4);
    expect_res(8'h2A, 3'd3, 5'd2, 8'h02);
    send_beat("xximap.q", 8'hFF, 1'b1, 8'h2A, 3'd3);
    repeat (5) @(negedge clk);
    check("t1_valid_after_e5", 32'(bus.o_res_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_after_e6", 32'(bus.o_res_valid), 32'd1);
    check("t1_flow_id_type", 32'(bus.o_flow_id_type), 32'h2A62);
    wait_drain("t1_drain");

    // Matches spanning a beat boundary.
    program_pat(0, "mail", 8'd4);
    program_pat(2, "ftp", 8'd3);
    expect_res(8'h11, 3'd1, 5'd1, 8'h05);
    send_beat("......ma", 8'hFF, 1'b0, 8'h99, 3'd7);
    send_beat("il.ftp..", 8'hFF, 1'b1, 8'h11, 3'd1);
    wait_drain("t2_drain");

    // No match across a message boundary; bytes outside keep are ignored.
    expect_res(8'h03, 3'd2, 5'd0, 8'h00);
    expect_res(8'h04, 3'd5, 5'd0, 8'h00);
    send_beat(".....ima", 8'hFF, 1'b1, 8'h03, 3'd2);
    send_beat("p.xmail.", 8'hE0, 1'b1, 8'h04, 3'd5);
    wait_drain("t3_drain");

    // Odd tail, disabled slots, length clipping, empty last beat.
    cfg_write(0, 0, 1'b1, 8'd0);
    cfg_write(1, 0, 1'b1, 8'd0);
    cfg_write(2, 0, 1'b1, 8'd0);
    program_pat(3, "p.co", 8'd4);
    program_pat(4, ".cox", 8'd4);
    program_pat(5, "imap.cox", 8'hFF);
    expect_res(8'h05, 3'd0, 5'd4, 8'h08);
    send_beat("imap.cox", 8'hFE, 1'b1, 8'h05, 3'd0);
    expect_res(8'h06, 3'd7, 5'd4, 8'h38);
    send_beat("imap.cox", 8'hFF, 1'b1, 8'h06, 3'd7);
    expect_res(8'h07, 3'd1, 5'd4, 8'h08);
    send_beat("xxxxp.co", 8'hFF, 1'b0, 8'h77, 3'd0);
    send_beat("", 8'h00, 1'b1, 8'h07, 3'd1);
    wait_drain("t4_drain");

    // Backpressure: hold a result while the FIFO fills.
    bus.i_res_ready = 1'b0;
    expect_res(8'h40, 3'd2, 5'd4, 8'h08);
    send_beat("xxp.coyy", 8'hFF, 1'b1, 8'h40, 3'd2);
    n = 0;
    while (!bus.o_res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_first_result_valid", 32'(bus.o_res_valid), 32'd1);
    held_fit  = bus.o_flow_id_type;
    held_mask = bus.o_hit_mask;
    stable    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        expect_res(8'(8'h80 + i), 3'(i), 5'd4, 8'h08);
        send_beat("xxp.coyy", 8'hFF, 1'b1, 8'(8'h80 + i), 3'(i));
      end else begin
        expect_res(8'(8'h80 + i), 3'(i), 5'd0, 8'h00);
        send_beat("zzzzzzzz", 8'hFF, 1'b1, 8'(8'h80 + i), 3'(i));
      end
      if (bus.o_flow_id_type !== held_fit || bus.o_hit_mask !== held_mask) stable = 1'b0;
    end
    check("t5_ready_low_after_16", 32'(bus.o_ready), 32'd0);
    expect_res(8'h90, 3'd0, 5'd4, 8'h08);
    bus.i_data      = str8("xxp.coyy");
    bus.i_keep      = 8'hFF;
    bus.i_last      = 1'b1;
    bus.i_flow_id   = 8'h90;
    bus.i_flow_type = 3'd0;
    bus.i_valid     = 1'b1;
    early = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.o_ready) early = 1'b1;
      if (bus.o_flow_id_type !== held_fit || bus.o_hit_mask !== held_mask) stable = 1'b0;
    end
    check("t5_17th_blocked", 32'(early), 32'd0);
    check("t5_held_stable", 32'(stable), 32'd1);
    check("t5_held_flow_id_type", 32'(bus.o_flow_id_type), 32'h4044);
    check("t5_held_valid", 32'(bus.o_res_valid), 32'd1);
    bus.i_res_ready = 1'b1;
    n = 0;
    while (!bus.o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_ready_returns", 32'(bus.o_ready), 32'd1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    wait_drain("t5_drain");

    // Config write while busy is dropped.
    expect_res(8'h50, 3'd1, 5'd4, 8'h08);
    send_beat("xxp.coyy", 8'hFF, 1'b1, 8'h50, 3'd1);
    cfg_write(3, 0, 1'b1, 8'd0);
    check("t6_cfg_err_pulse", 32'(cfg_err), 32'd1);
    @(negedge clk);
    check("t6_cfg_err_one_cycle", 32'(cfg_err), 32'd0);
    wait_drain("t6_drain");
    expect_res(8'h51, 3'd2, 5'd4, 8'h08);
    send_beat("xxp.coyy", 8'hFF, 1'b1, 8'h51, 3'd2);
    wait_drain("t6_pattern_kept");

    // Reset while scanning.
    send_beat("imap.cox", 8'hFF, 1'b1, 8'h60, 3'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t7_rst_res_valid", 32'(bus.o_res_valid), 32'd0);
    check("t7_rst_flow_id_type", 32'(bus.o_flow_id_type), 32'd0);
    check("t7_rst_hit_mask", 32'(bus.o_hit_mask), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_ready", 32'(bus.o_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t7_no_stale_result", 32'(bus.o_res_valid), 32'd0);
    expect_res(8'h61, 3'd0, 5'd0, 8'h00);
    send_beat("imap.cox", 8'hFF, 1'b1, 8'h61, 3'd0);
    wait_drain("t7_lengths_cleared");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
